// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg
// Shared definitions for the instruction-fetch front end: default widths,
// reset PC, NOP encoding, PC step and the fetch request FSM encoding.
package if_prefetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam int          DEPTH_DEFAULT    = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam int unsigned PC_INC           = 32'd4;

  // IDLE: no request outstanding; REQ: request whose data will be queued;
  // REQ_DROP: request still outstanding but made stale by a redirect.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_REQ_DROP = 2'd2
  } fetch_state_e;

endpackage : if_prefetch_pkg

// File: rtl/if_prefetch_fifo.sv
// if_prefetch_fifo
// DEPTH-entry circular buffer of {pc, instruction} pairs feeding decode.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               synchronous clear of all entries (wins over push/pop)
//   push, push_pc/inst  write one entry at the tail
//   pop                 remove the head entry
//   head_valid/pc/inst  combinational view of the head entry
//   count               number of valid entries (0..DEPTH)
module if_prefetch_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [XLEN-1:0]        push_pc,
  input  logic [XLEN-1:0]        push_inst,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [XLEN-1:0]        head_pc,
  output logic [XLEN-1:0]        head_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]     head_r;
  logic [AW-1:0]     tail_r;
  logic [AW:0]       count_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify push/pop so the buffer never overflows or underflows.
  always_comb begin
    do_push_s = push & (count_r != FULL_CNT);
    do_pop_s  = pop  & (count_r != CNT_ZERO);
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (flush) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (do_push_s) tail_r <= tail_r + PTR_ONE;
      if (do_pop_s)  head_r <= head_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed while the entry is counted.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush && !rst) begin
      mem[tail_r] <= {push_pc, push_inst};
    end
  end

  // Head view for decode.
  always_comb begin
    head_valid           = (count_r != CNT_ZERO);
    {head_pc, head_inst} = mem[head_r];
  end

  assign count = count_r;

endmodule : if_prefetch_fifo

// File: rtl/if_prefetch.sv
// if_prefetch
// Instruction-fetch front end: registered fetch PC, single-outstanding
// memory request handshake and a DEPTH-entry prefetch queue toward decode.
// A redirect from EX flushes the queue; a request still in flight at the
// time of a redirect completes and its data is thrown away.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ex_if_pce, ex_if_pc   one-cycle redirect strobe and target
//   stl                   blocks issue of new requests
//   mem_req, mem_addr     registered fetch request and word address
//   mem_ack, mem_data     one-cycle response strobe and instruction word
//   id_valid/pc/is        queue head toward decode (zeroed when invalid)
//   id_ready              decode consumes head on id_valid & id_ready
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_if_pce,
  input  logic [XLEN-1:0] ex_if_pc,
  input  logic            stl,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_is,
  input  logic            id_ready
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW+1:0] OCC_LIMIT = (AW+2)'(DEPTH);

  fetch_state_e    state_r;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] target_s;
  logic [AW:0]     fifo_count_s;
  logic [AW+1:0]   occupancy_s;
  logic            room_s;
  logic            fifo_push_s;
  logic            fifo_pop_s;
  logic            head_valid_s;
  logic [XLEN-1:0] head_pc_s;
  logic [XLEN-1:0] head_inst_s;
  logic            target_lsb_unused;

  assign target_lsb_unused = ^ex_if_pc[1:0];

  // Redirect target alignment, slot reservation and queue controls.
  always_comb begin
    target_s    = {ex_if_pc[XLEN-1:2], 2'b00};
    // The outstanding request already owns a slot in the queue.
    occupancy_s = {1'b0, fifo_count_s} + {{(AW+1){1'b0}}, mem_req};
    room_s      = (occupancy_s < OCC_LIMIT);
    fifo_push_s = mem_ack & (state_r == ST_REQ) & ~ex_if_pce;
    fifo_pop_s  = head_valid_s & id_ready & ~ex_if_pce;
  end

  // Request FSM with fetch PC; mem_req/mem_addr are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= {XLEN{1'b0}};
      fetch_pc_r <= RESET_PC;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ex_if_pce) begin
            fetch_pc_r <= target_s;
          end else if (!stl && room_s) begin
            state_r  <= ST_REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc_r;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_r <= ST_IDLE;
            mem_req <= 1'b0;
            // Redirect in the ack cycle discards the data without arming drop.
            if (ex_if_pce) fetch_pc_r <= target_s;
            else           fetch_pc_r <= fetch_pc_r + XLEN'(PC_INC);
          end else if (ex_if_pce) begin
            state_r    <= ST_REQ_DROP;
            fetch_pc_r <= target_s;
          end
        end
        ST_REQ_DROP: begin
          if (mem_ack) begin
            state_r <= ST_IDLE;
            mem_req <= 1'b0;
          end
          if (ex_if_pce) fetch_pc_r <= target_s;
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

  if_prefetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (ex_if_pce),
    .push       (fifo_push_s),
    .push_pc    (mem_addr),
    .push_inst  (mem_data),
    .pop        (fifo_pop_s),
    .head_valid (head_valid_s),
    .head_pc    (head_pc_s),
    .head_inst  (head_inst_s),
    .count      (fifo_count_s)
  );

  // Decode-facing view; payload is forced to zero while nothing is valid.
  always_comb begin
    id_valid = head_valid_s;
    if (head_valid_s) begin
      id_pc = head_pc_s;
      id_is = head_inst_s;
    end else begin
      id_pc = {XLEN{1'b0}};
      id_is = {XLEN{1'b0}};
    end
  end

endmodule : if_prefetch

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch
// Directed bench for if_prefetch (XLEN=32, DEPTH=4, RESET_PC=0). Inputs are
// driven and outputs sampled on the falling edge; the design acts on rising.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_if_pce;
  logic [31:0] ex_if_pc;
  logic        stl;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_is;
  logic        id_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_prefetch dut (
    .clk       (clk),
    .rst       (rst),
    .ex_if_pce (ex_if_pce),
    .ex_if_pc  (ex_if_pc),
    .stl       (stl),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_is     (id_is),
    .id_ready  (id_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; ex_if_pce = 1'b0; ex_if_pc = 32'h0; stl = 1'b0;
    mem_ack = 1'b0; mem_data = 32'h0; id_ready = rdy;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Bounded wait for a request; a timeout shows up as a failed comparison.
  task automatic wait_req(input string tag);
    int k = 0;
    while (!mem_req && k < 20) begin
      tick();
      k++;
    end
    check(tag, {31'h0, mem_req}, 32'h1);
  endtask

  // Wait for the request, check its address, answer after 'lat' cycles.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic [31:0] data, input int lat);
    wait_req({tag, "_req"});
    check({tag, "_addr"}, mem_addr, exp_addr);
    for (int i = 0; i < lat; i++) tick();
    mem_ack = 1'b1; mem_data = data;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then first request straight after reset release.
    rst = 1'b1; ex_if_pce = 1'b0; ex_if_pc = 32'h0; stl = 1'b0;
    mem_ack = 1'b0; mem_data = 32'h0; id_ready = 1'b1;
    tick(); tick();
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_is", id_is, 32'h0);
    rst = 1'b0;
    tick();
    check("first_req", {31'h0, mem_req}, 32'h1);
    check("first_addr", mem_addr, 32'h0);

    // Sequential fetch, ack two cycles after request, decode always ready.
    for (int i = 0; i < 4; i++) begin
      serve("seq", 32'(i * 4), 32'hA000_0000 + 32'(i), 1);
      check("seq_valid", {31'h0, id_valid}, 32'h1);
      check("seq_pc", id_pc, 32'(i * 4));
      check("seq_is", id_is, 32'hA000_0000 + 32'(i));
      check("seq_idle", {31'h0, mem_req}, 32'h0);
    end

    // Decode stalled: exactly DEPTH words accepted, then issue stops.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) serve("fill", 32'(i * 4), 32'hB000_0000 + 32'(i), 0);
    for (int i = 0; i < 6; i++) tick();
    check("full_noreq", {31'h0, mem_req}, 32'h0);
    check("full_head", id_pc, 32'h0);
    check("full_is", id_is, 32'hB000_0000);
    id_ready = 1'b1;
    tick();
    check("drain_pc1", id_pc, 32'h4);
    tick();
    check("drain_pc2", id_pc, 32'h8);
    check("resume_req", {31'h0, mem_req}, 32'h1);
    check("resume_addr", mem_addr, 32'h10);

    // Redirect to 0x103 while the request for 0x8 is outstanding.
    do_reset(1'b0);
    serve("rd", 32'h0, 32'hC000_0000, 0);
    serve("rd", 32'h4, 32'hC000_0001, 0);
    wait_req("rd8_req");
    check("rd8_addr", mem_addr, 32'h8);
    ex_if_pce = 1'b1; ex_if_pc = 32'h0000_0103;
    tick();
    ex_if_pce = 1'b0; ex_if_pc = 32'h0;
    check("rd_flush", {31'h0, id_valid}, 32'h0);
    check("rd_hold_req", {31'h0, mem_req}, 32'h1);
    check("rd_hold_addr", mem_addr, 32'h8);
    tick();
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    check("rd_dropped", {31'h0, id_valid}, 32'h0);
    serve("rd_tgt", 32'h100, 32'hC000_0100, 0);
    check("rd_tgt_pc", id_pc, 32'h100);
    check("rd_tgt_is", id_is, 32'hC000_0100);

    // Redirect coinciding with the ack for 0x8.
    do_reset(1'b1);
    serve("ra", 32'h0, 32'hD000_0000, 0);
    serve("ra", 32'h4, 32'hD000_0001, 0);
    wait_req("ra8_req");
    check("ra8_addr", mem_addr, 32'h8);
    mem_ack = 1'b1; mem_data = 32'hD000_0002;
    ex_if_pce = 1'b1; ex_if_pc = 32'h0000_0200;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0; ex_if_pce = 1'b0; ex_if_pc = 32'h0;
    check("ra_discard", {31'h0, id_valid}, 32'h0);
    check("ra_idle", {31'h0, mem_req}, 32'h0);
    serve("ra_tgt", 32'h200, 32'hD000_0200, 0);
    check("ra_nodrop_v", {31'h0, id_valid}, 32'h1);
    check("ra_nodrop_pc", id_pc, 32'h200);

    // Stall with nothing in flight, then stall over an in-flight request.
    stl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stl_noreq", {31'h0, mem_req}, 32'h0);
    end
    stl = 1'b0;
    wait_req("stl_req");
    check("stl_addr", mem_addr, 32'h204);
    stl = 1'b1;
    tick();
    mem_ack = 1'b1; mem_data = 32'hE000_0204;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    check("stl_ack_v", {31'h0, id_valid}, 32'h1);
    check("stl_ack_pc", id_pc, 32'h204);
    tick(); tick();
    check("stl_hold", {31'h0, mem_req}, 32'h0);
    stl = 1'b0;
    serve("stl_next", 32'h208, 32'hE000_0208, 0);

    // Address wrap at the top of the address space.
    ex_if_pce = 1'b1; ex_if_pc = 32'hFFFF_FFFF;
    tick();
    ex_if_pce = 1'b0; ex_if_pc = 32'h0;
    serve("wrap", 32'hFFFF_FFFC, 32'hF000_0001, 0);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    serve("wrap0", 32'h0, 32'hF000_0002, 0);
    check("wrap0_pc", id_pc, 32'h0);

    // Reset with a request for 0x4 outstanding; stray ack afterwards.
    wait_req("mid_req");
    check("mid_addr", mem_addr, 32'h4);
    rst = 1'b1;
    tick();
    check("mid_rst_req", {31'h0, mem_req}, 32'h0);
    check("mid_rst_addr", mem_addr, 32'h0);
    rst = 1'b0; stl = 1'b1; mem_ack = 1'b1; mem_data = 32'h1234_5678;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    check("stray_valid", {31'h0, id_valid}, 32'h0);
    check("stray_req", {31'h0, mem_req}, 32'h0);
    stl = 1'b0;
    serve("restart", 32'h0, 32'h9000_0000, 0);
    check("restart_pc", id_pc, 32'h0);
    check("restart_is", id_is, 32'h9000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_if_prefetch
